// File: rtl/leaf_pkg.sv
// Shared leaf-interface definitions: BFT packet geometry, field offsets and FSM encoding.
// Used by the egress packetizer, the ingress depacketizer and the leaf arbiter.
package leaf_pkg;

  localparam int PACKET_BITS           = 49;
  localparam int PAYLOAD_BITS          = 32;
  localparam int NUM_LEAF_BITS         = 5;
  localparam int NUM_PORT_BITS         = 4;
  localparam int NUM_ADDR_BITS         = 7;
  localparam int FREESPACE_UPDATE_SIZE = 64;
  localparam int BUF_DEPTH             = 1 << NUM_ADDR_BITS;

  // Packet layout, LSB upward: payload | addr | port | leaf | valid marker
  localparam int PAYLOAD_LSB = 0;
  localparam int ADDR_LSB    = PAYLOAD_LSB + PAYLOAD_BITS;
  localparam int PORT_LSB    = ADDR_LSB + NUM_ADDR_BITS;
  localparam int LEAF_LSB    = PORT_LSB + NUM_PORT_BITS;
  localparam int VLD_BIT     = LEAF_LSB + NUM_LEAF_BITS;

  typedef logic [PACKET_BITS-1:0]   packet_t;
  typedef logic [NUM_LEAF_BITS-1:0] leaf_t;
  typedef logic [NUM_PORT_BITS-1:0] port_t;
  typedef logic [NUM_ADDR_BITS-1:0] addr_t;
  typedef logic [PAYLOAD_BITS-1:0]  payload_t;

  localparam logic [0:0] ST_UNCFG = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  function automatic packet_t make_packet(input leaf_t leaf, input port_t port,
                                          input addr_t addr, input payload_t payload);
    return {1'b1, leaf, port, addr, payload};
  endfunction

endpackage

// File: rtl/leaf_out_packetizer_if.sv
// Bundle of user stream, configuration, credit return and arbiter handshake
// signals for one egress port; slave is the packetizer, master is everything around it.
interface leaf_out_packetizer_if;
  import leaf_pkg::*;

  payload_t din_leaf_user2interface;
  logic     vld_user2interface;
  logic     ack_interface2user;
  leaf_t    cfg_dest_leaf;
  port_t    cfg_dest_port;
  logic     cfg_vld;
  logic     freespace_upd;
  logic     resend;
  packet_t  pkt_out;
  logic     pkt_vld;
  logic     pkt_ack;
  logic     credit_err;

  modport master (
    output din_leaf_user2interface, vld_user2interface, cfg_dest_leaf, cfg_dest_port,
           cfg_vld, freespace_upd, resend, pkt_ack,
    input  ack_interface2user, pkt_out, pkt_vld, credit_err
  );

  modport slave (
    input  din_leaf_user2interface, vld_user2interface, cfg_dest_leaf, cfg_dest_port,
           cfg_vld, freespace_upd, resend, pkt_ack,
    output ack_interface2user, pkt_out, pkt_vld, credit_err
  );

endinterface

// File: rtl/leaf_credit_counter.sv
// Saturating credit counter: -1 per consumed entry, +STEP per freespace return.
// Any result above MAX clamps to MAX and sets a sticky error flag.
module leaf_credit_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 128,
  parameter int STEP  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_dec,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count,
  output logic             o_err
);

  localparam logic [WIDTH:0] L_MAX  = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0] L_STEP = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] L_ONE  = (WIDTH+1)'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_err;
  logic [WIDTH:0]   w_sum;

  // One extra bit so count + STEP never wraps before the saturation compare
  always_comb begin
    w_sum = {1'b0, r_count};
    if (i_inc) w_sum = w_sum + L_STEP;
    if (i_dec) w_sum = w_sum - L_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= L_MAX[WIDTH-1:0];
      r_err   <= 1'b0;
    end else if (w_sum > L_MAX) begin
      r_count <= L_MAX[WIDTH-1:0];
      r_err   <= 1'b1;
    end else begin
      r_count <= w_sum[WIDTH-1:0];
    end
  end

  assign o_count = r_count;
  assign o_err   = r_err;

endmodule

// File: rtl/leaf_out_packetizer.sv
// Egress packetizer: wraps each accepted user word into a BFT packet for the arbiter,
// gated by destination credits and frozen while the arbiter requests a resend.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_UNCFG | no destination latched; user stream and packet output idle
// ST_RUN   | destination latched; words accepted while credits remain
module leaf_out_packetizer
  import leaf_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  leaf_out_packetizer_if.slave  bus
);

  logic [0:0]         r_state;
  leaf_t              r_dest_leaf;
  port_t              r_dest_port;
  addr_t              r_addr;
  packet_t            r_pkt;
  logic               r_pkt_vld;
  logic [NUM_ADDR_BITS:0] w_credit;
  logic               w_ack;
  logic               w_accept;
  logic               w_cfg_take;

  assign w_ack = (r_state == ST_RUN) && !bus.resend && (w_credit != '0) &&
                 (!r_pkt_vld || bus.pkt_ack);
  assign w_accept = w_ack && bus.vld_user2interface;
  // Retargeting is refused while a packet is outstanding so it keeps its original header
  assign w_cfg_take = bus.cfg_vld && !bus.resend && ((r_state == ST_UNCFG) || !r_pkt_vld);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_UNCFG;
      r_dest_leaf <= '0;
      r_dest_port <= '0;
    end else if (w_cfg_take) begin
      r_state     <= ST_RUN;
      r_dest_leaf <= bus.cfg_dest_leaf;
      r_dest_port <= bus.cfg_dest_port;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
    end else if (w_accept) begin
      r_addr <= r_addr + addr_t'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pkt     <= '0;
      r_pkt_vld <= 1'b0;
    end else if (w_accept) begin
      r_pkt     <= make_packet(r_dest_leaf, r_dest_port, r_addr, bus.din_leaf_user2interface);
      r_pkt_vld <= 1'b1;
    end else if (bus.pkt_ack && !bus.resend) begin
      r_pkt_vld <= 1'b0;
    end
  end

  leaf_credit_counter #(
    .WIDTH (NUM_ADDR_BITS + 1),
    .MAX   (BUF_DEPTH),
    .STEP  (FREESPACE_UPDATE_SIZE)
  ) u_credit (
    .clk     (clk),
    .reset   (reset),
    .i_dec   (w_accept),
    .i_inc   (bus.freespace_upd),
    .o_count (w_credit),
    .o_err   (bus.credit_err)
  );

  assign bus.ack_interface2user = w_ack;
  assign bus.pkt_out            = r_pkt;
  assign bus.pkt_vld            = r_pkt_vld && !bus.resend;

endmodule

// File: tb/tb_leaf_out_packetizer.sv
// Directed bench for leaf_out_packetizer: a driver pushes hand-built expected packets,
// a separate monitor pops and compares on every arbiter handshake.
module tb_leaf_out_packetizer;

  logic clk = 1'b0;
  logic reset;

  leaf_out_packetizer_if bus();

  leaf_out_packetizer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_obs    = 0;

  logic [48:0] exp_q[$];
  logic [4:0]  m_leaf;
  logic [3:0]  m_port;
  logic [6:0]  m_addr;

  function automatic logic [48:0] pkt(input logic [4:0] l, input logic [3:0] p,
                                      input logic [6:0] a, input logic [31:0] d);
    return {1'b1, l, p, a, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus; ack checked mid-cycle, expected packet queued at the edge
  task automatic cycle(input logic vld, input logic [31:0] data, input logic pack,
                       input logic fsu, input logic rs, input logic exp_ack, input string name);
    bus.vld_user2interface      = vld;
    bus.din_leaf_user2interface = data;
    bus.pkt_ack                 = pack;
    bus.freespace_upd           = fsu;
    bus.resend                  = rs;
    @(negedge clk);
    check(name, 64'(bus.ack_interface2user), 64'(exp_ack));
    if (vld && bus.ack_interface2user) n_obs++;
    @(posedge clk);
    if (vld && exp_ack) begin
      exp_q.push_back(pkt(m_leaf, m_port, m_addr, data));
      m_addr = m_addr + 7'd1;
    end
    #1;
  endtask

  task automatic idle(input logic pack, input int n);
    bus.vld_user2interface = 1'b0;
    bus.pkt_ack            = pack;
    bus.freespace_upd      = 1'b0;
    bus.resend             = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset                  = 1'b1;
    bus.vld_user2interface = 1'b0;
    bus.pkt_ack            = 1'b0;
    bus.freespace_upd      = 1'b0;
    bus.resend             = 1'b0;
    bus.cfg_vld            = 1'b0;
    exp_q.delete();
    m_addr = 7'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic configure(input logic [4:0] l, input logic [3:0] p);
    bus.cfg_dest_leaf = l;
    bus.cfg_dest_port = p;
    bus.cfg_vld       = 1'b1;
    @(posedge clk);
    #1;
    bus.cfg_vld = 1'b0;
    m_leaf = l;
    m_port = p;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.pkt_vld && bus.pkt_ack) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL scoreboard: got packet 0x%0h expected none", bus.pkt_out);
        end else begin
          check("scoreboard", 64'(bus.pkt_out), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    bus.din_leaf_user2interface = '0;
    bus.vld_user2interface      = 1'b0;
    bus.cfg_dest_leaf           = '0;
    bus.cfg_dest_port           = '0;
    bus.cfg_vld                 = 1'b0;
    bus.freespace_upd           = 1'b0;
    bus.resend                  = 1'b0;
    bus.pkt_ack                 = 1'b0;
    m_leaf = '0;
    m_port = '0;
    m_addr = '0;
    reset  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 64'(bus.ack_interface2user), 64'd0);
    check("rst_pkt_vld", 64'(bus.pkt_vld), 64'd0);
    check("rst_pkt_out", 64'(bus.pkt_out), 64'd0);
    check("rst_credit_err", 64'(bus.credit_err), 64'd0);
    reset = 1'b0;

    // Unconfigured: user valid must not be acknowledged
    cycle(1'b1, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 1'b0, "uncfg_ack");

    // First word after configuration
    configure(5'd3, 4'd2);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1, "first_ack");
    check("first_pkt_vld", 64'(bus.pkt_vld), 64'd1);
    check("first_pkt_out", 64'(bus.pkt_out), 64'h1_1900_DEAD_BEEF);
    cycle(1'b1, 32'hCAFE_0001, 1'b0, 1'b0, 1'b0, 1'b0, "held_ack");
    idle(1'b1, 1);

    // Credit exhaustion: 130 offered, 128 taken, addresses 0..127
    do_reset();
    configure(5'd3, 4'd2);
    n_obs = 0;
    for (int i = 0; i < 130; i++)
      cycle(1'b1, 32'h100 + i, 1'b1, 1'b0, 1'b0, (i < 128), "burst_ack");
    check("burst_count", 64'(n_obs), 64'd128);
    idle(1'b1, 2);
    check("credit0_ack", 64'(bus.ack_interface2user), 64'd0);

    // One freespace update refills 64 credits; addresses wrapped back to 0
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, "fsu_cycle_ack");
    n_obs = 0;
    for (int i = 0; i < 66; i++) begin
      cycle(1'b1, 32'h2000 + i, 1'b1, 1'b0, 1'b0, (i < 64), "refill_ack");
      if (i == 0) check("refill_first_addr", 64'(bus.pkt_out[38:32]), 64'd0);
    end
    check("refill_count", 64'(n_obs), 64'd64);
    idle(1'b1, 2);

    // Arbiter backpressure: one word taken, packet held stable for 9 cycles
    do_reset();
    configure(5'd7, 4'd9);
    n_obs = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, (i == 0) ? 32'h3000 : 32'h3001, 1'b0, 1'b0, 1'b0, (i == 0), "stall_ack");
      check("stall_pkt_out", 64'(bus.pkt_out), 64'(pkt(5'd7, 4'd9, 7'd0, 32'h3000)));
    end
    check("stall_count", 64'(n_obs), 64'd1);
    for (int j = 0; j < 5; j++)
      cycle(1'b1, 32'h3001 + j, 1'b1, 1'b0, 1'b0, 1'b1, "stream_ack");
    check("stream_count", 64'(n_obs), 64'd6);

    // Resend freezes the pending packet; arbiter ack and user valid are ignored
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 32'h4000, 1'b1, 1'b0, 1'b1, 1'b0, "resend_ack");
      check("resend_pkt_vld", 64'(bus.pkt_vld), 64'd0);
      check("resend_pkt_out", 64'(bus.pkt_out), 64'(pkt(5'd7, 4'd9, 7'd5, 32'h3005)));
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "post_resend_ack");
    check("represent_vld", 64'(bus.pkt_vld), 64'd1);
    check("represent_pkt", 64'(bus.pkt_out), 64'(pkt(5'd7, 4'd9, 7'd5, 32'h3005)));
    cycle(1'b1, 32'h5000, 1'b1, 1'b0, 1'b0, 1'b1, "after_resend_ack");

    // Asynchronous reset drops the in-flight packet immediately
    idle(1'b0, 1);
    check("inflight_vld", 64'(bus.pkt_vld), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_rst_vld", 64'(bus.pkt_vld), 64'd0);
    check("async_rst_pkt", 64'(bus.pkt_out), 64'd0);

    // Update at full credit saturates and sets the sticky error
    do_reset();
    configure(5'd1, 4'd1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, "fsu_full_ack");
    check("err_set", 64'(bus.credit_err), 64'd1);
    idle(1'b0, 3);
    check("err_sticky", 64'(bus.credit_err), 64'd1);
    cycle(1'b1, 32'h6000, 1'b1, 1'b0, 1'b0, 1'b1, "err_accept_ack");
    idle(1'b1, 1);
    check("err_after_accept", 64'(bus.credit_err), 64'd1);
    do_reset();
    check("err_cleared", 64'(bus.credit_err), 64'd0);

    // Accept + update at credit 100: 163 clamps to 128, error set, 128 more accepted
    configure(5'd1, 4'd1);
    for (int i = 0; i < 28; i++)
      cycle(1'b1, 32'h7000 + i, 1'b1, 1'b0, 1'b0, 1'b1, "pre_sat_ack");
    check("pre_sat_err", 64'(bus.credit_err), 64'd0);
    cycle(1'b1, 32'h7100, 1'b1, 1'b1, 1'b0, 1'b1, "sat_ack");
    check("sat_err", 64'(bus.credit_err), 64'd1);
    n_obs = 0;
    for (int i = 0; i < 129; i++)
      cycle(1'b1, 32'h8000 + i, 1'b1, 1'b0, 1'b0, (i < 128), "post_sat_ack");
    check("post_sat_count", 64'(n_obs), 64'd128);
    idle(1'b1, 2);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/leaf_out_packetizer.md
# leaf_out_packetizer

Per-output-port packetizer between a user kernel output stream (32-bit vld/ack) and the leaf interface's BFT egress arbiter. Each accepted user word becomes one 49-bit BFT packet addressed to a configured destination leaf/port, tagged with a wrapping 7-bit buffer address. Credit-based flow control keeps the destination's 128-entry input BRAM from overflowing. One instance per output port; NUM_OUT_PORTS instances feed the arbiter.

## Interface
- PACKET_BITS, 49, BFT packet width
- PAYLOAD_BITS, 32, user data width
- NUM_LEAF_BITS, 5, destination leaf field width
- NUM_PORT_BITS, 4, destination port field width
- NUM_ADDR_BITS, 7, destination buffer address width; depth = 2^NUM_ADDR_BITS = 128
- FREESPACE_UPDATE_SIZE, 64, credit quantum returned per freespace update
- clk, in, 1, leaf clock; one clock domain, all logic on rising edge
- reset, in, 1, asynchronous, active-high
- din_leaf_user2interface, in, PAYLOAD_BITS, user word
- vld_user2interface, in, 1, user word valid
- ack_interface2user, out, 1, word accepted this cycle
- cfg_dest_leaf, in, NUM_LEAF_BITS, destination leaf
- cfg_dest_port, in, NUM_PORT_BITS, destination port
- cfg_vld, in, 1, one-cycle pulse latching cfg_dest_*
- freespace_upd, in, 1, one-cycle pulse: destination freed FREESPACE_UPDATE_SIZE entries
- resend, in, 1, freeze: no accepts, no packet presentation, no state change
- pkt_out, out, PACKET_BITS, {1'b1, leaf, port, addr, payload}, MSB first
- pkt_vld, out, 1, pkt_out holds a packet
- pkt_ack, in, 1, arbiter takes pkt_out this cycle
- credit_err, out, 1, sticky: credit counter would exceed depth

## Operation
- FSM: UNCFG -> RUN on cfg_vld. In RUN, a further cfg_vld is accepted only when pkt_vld=0; otherwise it is ignored. Reset -> UNCFG.
- UNCFG: ack_interface2user=0, pkt_vld=0.
- Credit counter is NUM_ADDR_BITS+1 bits wide. It resets to 128 and is decremented on each accepted word.
- On freespace_upd, the counter gains FREESPACE_UPDATE_SIZE. If an accept and an update happen in the same cycle, the net change is +63.
- If the result would exceed 128, the counter saturates at 128 and credit_err sets. credit_err clears only on reset.
- Address counter, NUM_ADDR_BITS wide: resets to 0, increments on each accept, wraps 127 -> 0.
- Single output register. ack_interface2user = RUN & !resend & (credit != 0) & (!pkt_vld | pkt_ack).
- Accept means vld_user2interface & ack_interface2user. On accept, the register loads {1, dest_leaf, dest_port, addr, din_leaf_user2interface} and pkt_vld=1.
- A pkt_ack without a same-cycle accept clears pkt_vld. Back-to-back throughput is one packet per cycle while pkt_ack is held high.
- While resend=1: pkt_vld is forced low at the output, the register retains its contents, counters hold, freespace_upd is still applied, and pkt_ack is ignored.
- When resend falls, the held packet is re-presented.

## Timing
- Reset values: ack_interface2user=0, pkt_vld=0, pkt_out=0, credit_err=0, state UNCFG.
- Latency: a word accepted at edge N appears on pkt_out/pkt_vld after edge N (one cycle).
- Once asserted, pkt_vld and pkt_out are stable until pkt_ack (or resend) is seen. The arbiter may hold pkt_ack low indefinitely.
- ack_interface2user is combinational from state, credit, pkt_vld, pkt_ack and resend. It has no combinational path from vld_user2interface.
- Credits reaching 0: ack drops in the cycle after the accept that consumed the last credit. A freespace_upd in that cycle restores ack on the next cycle.
- Reset asserted mid-packet drops the register contents immediately (asynchronous); the in-flight word is lost.

## Structure
- Shared package leaf_pkg: packet field offsets, the PACKET_BITS/PAYLOAD_BITS/NUM_*_BITS defaults, and FSM state encoding, shared with the ingress depacketizer and the leaf_interface arbiter.
- One sub-module, leaf_credit_counter: saturating up/down counter with the error flag, reused by the ingress freespace tracker.

## Test plan
- Reset, cfg_vld with leaf=5'd3, port=4'd2, user sends 0xDEADBEEF -> next cycle pkt_out = {1,3,2,7'd0,0xDEADBEEF}, pkt_vld=1.
- 130 words with pkt_ack held high and no updates -> exactly 128 accepted, ack low thereafter. Addresses 0..127 in order; the last has addr=127, and the next addr would wrap to 0.
- Credit at 0, then freespace_upd pulse -> 64 further words accepted; first new packet carries addr=0.
- pkt_ack low for 10 cycles with vld high -> one packet held stable and exactly one word accepted; pkt_ack then high -> one packet per cycle.
- resend high for 5 cycles with a pending packet -> pkt_vld=0 and counters frozen. After resend falls, the same packet is re-presented unchanged.
- freespace_upd at credit=128 -> credit stays 128 and credit_err=1 until reset; simultaneous accept+update at credit=100 -> credit 128 and saturated, so credit_err=1 (the raw sum 100-1+64=163 exceeds 128).
